// File: rtl/rsa_data_bridge_pkg.sv
// Shared widths and state encodings for the RSA data bridge.
package rsa_data_bridge_pkg;

    localparam int unsigned WORD_W  = 32;
    localparam int unsigned BLOCK_W = 1024;
    localparam int unsigned WORDS   = 32;
    localparam int unsigned CNT_W   = 5;

    typedef enum logic {
        PK_FILL = 1'b0,
        PK_HOLD = 1'b1
    } pack_state_e;

    typedef enum logic {
        UP_IDLE  = 1'b0,
        UP_DRAIN = 1'b1
    } unpack_state_e;

endpackage

// File: rtl/rsa_data_bridge_if.sv
// Handshake bundle between the ARM word streams and the 1024-bit wrapper ports.
interface rsa_data_bridge_if;
    import rsa_data_bridge_pkg::*;

    logic [WORD_W-1:0]  s_word;
    logic               s_word_valid;
    logic               s_word_ready;
    logic               pack_clear;
    logic [BLOCK_W-1:0] pk_data;
    logic               pk_valid;
    logic               pk_ready;
    logic [BLOCK_W-1:0] up_data;
    logic               up_valid;
    logic               up_ready;
    logic [WORD_W-1:0]  m_word;
    logic               m_word_valid;
    logic               m_word_ready;
    logic               m_word_last;

    // Environment side: drives inbound words, wrapper results and ARM readiness.
    modport master (
        output s_word, s_word_valid, pack_clear, pk_ready,
               up_data, up_valid, m_word_ready,
        input  s_word_ready, pk_data, pk_valid, up_ready,
               m_word, m_word_valid, m_word_last
    );

    // Bridge side.
    modport slave (
        input  s_word, s_word_valid, pack_clear, pk_ready,
               up_data, up_valid, m_word_ready,
        output s_word_ready, pk_data, pk_valid, up_ready,
               m_word, m_word_valid, m_word_last
    );

endinterface

// File: rtl/rsa_data_bridge_unpacker.sv
// Splits a 1024-bit result block into 32 words, least significant first.
module rsa_word_unpacker #(
    parameter int unsigned WORDS = 32
) (
    input  logic                                   clk,
    input  logic                                   resetn,
    input  logic [rsa_data_bridge_pkg::BLOCK_W-1:0] up_data_i,
    input  logic                                   up_valid_i,
    output logic                                   up_ready_o,
    output logic [rsa_data_bridge_pkg::WORD_W-1:0]  m_word_o,
    output logic                                   m_word_valid_o,
    input  logic                                   m_word_ready_i,
    output logic                                   m_word_last_o
);
    import rsa_data_bridge_pkg::*;

    unpack_state_e      state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [BLOCK_W-1:0] shift_q, shift_d;

    logic last_word;
    assign last_word = (cnt_q == CNT_W'(WORDS - 1));

    // State, counter and shift register; reset discards any undelivered words.
    always_ff @(posedge clk) begin
        if (resetn) begin
            state_q <= UP_IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
        end
    end

    // Load a block when idle, then shift one word out per accepted transfer.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        case (state_q)
            UP_IDLE: begin
                if (up_valid_i) begin
                    shift_d = up_data_i;
                    cnt_d   = '0;
                    state_d = UP_DRAIN;
                end
            end
            UP_DRAIN: begin
                if (m_word_ready_i) begin
                    shift_d = shift_q >> WORD_W;
                    if (last_word) begin
                        cnt_d   = '0;
                        state_d = UP_IDLE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = UP_IDLE;
        endcase
    end

    assign up_ready_o     = (state_q == UP_IDLE);
    assign m_word_valid_o = (state_q == UP_DRAIN);
    assign m_word_o       = shift_q[WORD_W-1:0];
    assign m_word_last_o  = (state_q == UP_DRAIN) && last_word;

endmodule

// File: rtl/rsa_data_bridge.sv
// Bridges 32-bit ARM word streams to the 1024-bit operand/result ports of the RSA wrapper.
module rsa_data_bridge #(
    parameter int unsigned WORDS = 32
) (
    input  logic             clk,
    input  logic             resetn,
    rsa_data_bridge_if.slave bus
);
    import rsa_data_bridge_pkg::*;

    pack_state_e        pk_state_q, pk_state_d;
    logic [CNT_W-1:0]   pk_cnt_q, pk_cnt_d;
    logic [BLOCK_W-1:0] pk_data_q, pk_data_d;

    // Packer registers; reset drops any partially packed operand.
    always_ff @(posedge clk) begin
        if (resetn) begin
            pk_state_q <= PK_FILL;
            pk_cnt_q   <= '0;
            pk_data_q  <= '0;
        end else begin
            pk_state_q <= pk_state_d;
            pk_cnt_q   <= pk_cnt_d;
            pk_data_q  <= pk_data_d;
        end
    end

    // Fill slices in order; clear beats a same-cycle word; hold until the wrapper takes the block.
    always_comb begin
        pk_state_d = pk_state_q;
        pk_cnt_d   = pk_cnt_q;
        pk_data_d  = pk_data_q;
        case (pk_state_q)
            PK_FILL: begin
                if (bus.pack_clear) begin
                    pk_cnt_d = '0;
                end else if (bus.s_word_valid) begin
                    pk_data_d[pk_cnt_q*WORD_W +: WORD_W] = bus.s_word;
                    if (pk_cnt_q == CNT_W'(WORDS - 1)) begin
                        pk_cnt_d   = '0;
                        pk_state_d = PK_HOLD;
                    end else begin
                        pk_cnt_d = pk_cnt_q + 1'b1;
                    end
                end
            end
            PK_HOLD: begin
                if (bus.pk_ready) pk_state_d = PK_FILL;
            end
            default: pk_state_d = PK_FILL;
        endcase
    end

    assign bus.s_word_ready = (pk_state_q == PK_FILL);
    assign bus.pk_valid     = (pk_state_q == PK_HOLD);
    assign bus.pk_data      = pk_data_q;

    rsa_word_unpacker #(
        .WORDS(WORDS)
    ) u_unpacker (
        .clk           (clk),
        .resetn        (resetn),
        .up_data_i     (bus.up_data),
        .up_valid_i    (bus.up_valid),
        .up_ready_o    (bus.up_ready),
        .m_word_o      (bus.m_word),
        .m_word_valid_o(bus.m_word_valid),
        .m_word_ready_i(bus.m_word_ready),
        .m_word_last_o (bus.m_word_last)
    );

endmodule

// File: tb/tb_rsa_data_bridge.sv
// Directed and randomized bench for rsa_data_bridge with a queue-based reference model.
module tb_rsa_data_bridge;

    logic clk;
    logic resetn;

    rsa_data_bridge_if bif();

    rsa_data_bridge #(.WORDS(32)) dut (
        .clk   (clk),
        .resetn(resetn),
        .bus   (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [1023:0] blk;
    int unsigned   mcnt;
    bit            mhold;
    bit            udrain;
    logic [1023:0] pk_q[$];
    logic [32:0]   m_q[$];
    int unsigned   packed_blocks;
    int unsigned   unpacked_blocks;

    task automatic chk(input string tag, input logic [1023:0] got, input logic [1023:0] exp);
        int unsigned w;
        w = 0;
        for (int i = 31; i >= 0; i--)
            if (got[i*32 +: 32] !== exp[i*32 +: 32]) w = i;
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: word %0d observed=%h expected=%h", tag, w, got[w*32 +: 32], exp[w*32 +: 32]);
        end
    endtask

    // Called at a negedge with inputs already driven: check outputs, model the edge, advance.
    task automatic tick();
        logic [32:0] e;
        if (!mhold) begin
            chk("s_word_ready_fill", bif.s_word_ready, 1);
            chk("pk_valid_fill", bif.pk_valid, 0);
            if (bif.pack_clear) begin
                mcnt = 0;
            end else if (bif.s_word_valid) begin
                blk[mcnt*32 +: 32] = bif.s_word;
                if (mcnt == 31) begin
                    mcnt  = 0;
                    mhold = 1;
                    pk_q.push_back(blk);
                end else begin
                    mcnt++;
                end
            end
        end else begin
            chk("s_word_ready_hold", bif.s_word_ready, 0);
            chk("pk_valid_hold", bif.pk_valid, 1);
            chk("pk_data", bif.pk_data, pk_q[0]);
            if (bif.pk_ready) begin
                void'(pk_q.pop_front());
                mhold = 0;
                packed_blocks++;
            end
        end

        if (!udrain) begin
            chk("up_ready_idle", bif.up_ready, 1);
            chk("m_valid_idle", bif.m_word_valid, 0);
            if (bif.up_valid) begin
                for (int i = 0; i < 32; i++)
                    m_q.push_back({(i == 31), bif.up_data[i*32 +: 32]});
                udrain = 1;
            end
        end else begin
            e = m_q[0];
            chk("up_ready_drain", bif.up_ready, 0);
            chk("m_valid_drain", bif.m_word_valid, 1);
            chk("m_word", bif.m_word, e[31:0]);
            chk("m_last", bif.m_word_last, e[32]);
            if (bif.m_word_ready) begin
                void'(m_q.pop_front());
                if (e[32]) begin
                    udrain = 0;
                    unpacked_blocks++;
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        resetn = 1'b1;
        @(posedge clk);
        @(negedge clk);
        resetn = 1'b0;
        mcnt   = 0;
        mhold  = 0;
        udrain = 0;
        pk_q.delete();
        m_q.delete();
        chk("rst_pk_valid", bif.pk_valid, 0);
        chk("rst_m_valid", bif.m_word_valid, 0);
        chk("rst_m_last", bif.m_word_last, 0);
        chk("rst_pk_data", bif.pk_data, '0);
        chk("rst_m_word", bif.m_word, 0);
        chk("rst_s_ready", bif.s_word_ready, 1);
        chk("rst_up_ready", bif.up_ready, 1);
    endtask

    task automatic load_up(input logic [31:0] base);
        for (int i = 0; i < 32; i++)
            bif.up_data[i*32 +: 32] = base + 32'(i);
    endtask

    initial begin
        int unsigned cyc;
        bif.s_word       = '0;
        bif.s_word_valid = 1'b0;
        bif.pack_clear   = 1'b0;
        bif.pk_ready     = 1'b0;
        bif.up_data      = '0;
        bif.up_valid     = 1'b0;
        bif.m_word_ready = 1'b0;
        blk              = '0;
        packed_blocks    = 0;
        unpacked_blocks  = 0;
        do_reset();

        // Continuous pack with the wrapper not ready
        bif.s_word_valid = 1'b1;
        for (int i = 0; i < 32; i++) begin
            bif.s_word = 32'(i);
            tick();
        end
        bif.s_word = 32'h5555_5555;
        tick();
        tick();
        chk("pack_lsw", bif.pk_data[31:0], 32'h0);
        chk("pack_msw", bif.pk_data[1023:992], 32'h1F);
        bif.s_word_valid = 1'b0;
        bif.pk_ready     = 1'b1;
        tick();
        bif.pk_ready = 1'b0;
        tick();

        // Clear discards the partial operand and the same-cycle word
        bif.s_word_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            bif.s_word = 32'h100 + 32'(i);
            tick();
        end
        bif.s_word     = 32'hDEAD;
        bif.pack_clear = 1'b1;
        tick();
        bif.pack_clear = 1'b0;
        for (int i = 0; i < 32; i++) begin
            bif.s_word = 32'h200 + 32'(i);
            tick();
        end
        bif.s_word_valid = 1'b0;
        tick();
        chk("clear_w0", bif.pk_data[31:0], 32'h200);
        chk("clear_w10", bif.pk_data[351:320], 32'h20A);
        bif.pk_ready = 1'b1;
        tick();
        bif.pk_ready = 1'b0;

        // Unpack with toggling ARM readiness
        load_up(32'hA0);
        bif.up_valid = 1'b1;
        tick();
        bif.up_valid = 1'b0;
        for (int i = 0; i < 64; i++) begin
            bif.m_word_ready = (i % 2 == 1);
            tick();
        end
        bif.m_word_ready = 1'b0;
        chk("unpack_done_ready", bif.up_ready, 1);
        chk("unpack_done_valid", bif.m_word_valid, 0);

        // Concurrent pack and unpack
        load_up(32'hC0);
        bif.up_valid     = 1'b1;
        bif.m_word_ready = 1'b1;
        bif.s_word_valid = 1'b1;
        for (int i = 0; i < 32; i++) begin
            bif.s_word = 32'h300 + 32'(i);
            tick();
            bif.up_valid = 1'b0;
        end
        bif.s_word_valid = 1'b0;
        chk("conc_pk_valid", bif.pk_valid, 1);
        chk("conc_last_pending", bif.m_word_last, 1);
        bif.pk_ready = 1'b1;
        tick();
        bif.pk_ready = 1'b0;
        chk("conc_pk_released", bif.pk_valid, 0);
        chk("conc_up_ready", bif.up_ready, 1);

        // Reset in the middle of a drain
        load_up(32'hE0);
        bif.up_valid = 1'b1;
        tick();
        bif.up_valid = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        do_reset();
        load_up(32'hF0);
        bif.up_valid = 1'b1;
        tick();
        bif.up_valid = 1'b0;
        chk("post_rst_first", bif.m_word, 32'hF0);
        for (int i = 0; i < 33; i++) tick();
        chk("post_rst_idle", bif.up_ready, 1);

        // Randomized handshakes on all ports
        packed_blocks   = 0;
        unpacked_blocks = 0;
        cyc             = 0;
        while ((packed_blocks < 100 || unpacked_blocks < 100) && cyc < 40000) begin
            bif.s_word_valid = ($urandom_range(3) != 0);
            bif.s_word       = $urandom;
            bif.pack_clear   = ($urandom_range(63) == 0);
            bif.pk_ready     = 1'($urandom_range(1));
            bif.up_valid     = 1'($urandom_range(1));
            for (int i = 0; i < 32; i++)
                bif.up_data[i*32 +: 32] = $urandom;
            bif.m_word_ready = ($urandom_range(3) != 0);
            tick();
            cyc++;
        end
        bif.s_word_valid = 1'b0;
        bif.pack_clear   = 1'b0;
        bif.up_valid     = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rsa_data_bridge.md
RSA_DATA_BRIDGE -- requirements
Module: rsa_data_bridge

Interface
REQ-001 Parameter WORDS, default 32, number of 32-bit words per 1024-bit operand; fixed at 32 for this design.
REQ-002 clk  input  1  single clock; all logic on rising edge.
REQ-003 resetn  input  1  synchronous, active-high reset; asserted = 1, sampled on rising clk edge.
REQ-004 s_word  input  32  ARM-side inbound word.
REQ-005 s_word_valid  input  1  s_word holds a valid word.
REQ-006 s_word_ready  output  1  bridge accepts s_word this cycle.
REQ-007 pack_clear  input  1  discard the partially packed operand.
REQ-008 pk_data  output  1024  packed operand, towards the wrapper's arm_to_fpga_data.
REQ-009 pk_valid  output  1  pk_data complete and held.
REQ-010 pk_ready  input  1  wrapper takes pk_data (its arm_to_fpga_data_ready).
REQ-011 up_data  input  1024  result block from the wrapper's fpga_to_arm_data.
REQ-012 up_valid  input  1  up_data valid (its fpga_to_arm_data_valid).
REQ-013 up_ready  output  1  bridge accepts up_data this cycle.
REQ-014 m_word  output  32  ARM-side outbound word.
REQ-015 m_word_valid  output  1  m_word valid.
REQ-016 m_word_ready  input  1  ARM accepts m_word.
REQ-017 m_word_last  output  1  m_word is word 31 of the block.

Function
REQ-018 Transfers on both sides SHALL occur only in a cycle where valid and ready are both 1.
REQ-019 The packer SHALL have two states: FILL and HOLD.
REQ-020 In FILL, s_word_ready = 1, pk_valid = 0, and a 5-bit word counter selects the slice.
REQ-021 The word accepted at count k SHALL be written to pk_data[32k+31:32k]; word 0 is the least significant.
REQ-022 After the word at count 31 is accepted, the packer SHALL enter HOLD on the next edge, with pk_valid = 1 in that cycle (one cycle latency) and the counter wrapped to 0.
REQ-023 In HOLD, s_word_ready = 0 and pk_data SHALL remain stable.
REQ-024 HOLD with pk_ready = 1 SHALL return the packer to FILL on the next edge; pk_valid SHALL stay 1 until that transfer.
REQ-025 pack_clear in FILL SHALL zero the counter; a word presented in the same cycle SHALL be discarded (clear wins).
REQ-026 pack_clear in HOLD SHALL be ignored.
REQ-027 The unpacker SHALL have two states: IDLE and DRAIN.
REQ-028 In IDLE, up_ready = 1 and m_word_valid = 0.
REQ-029 An up_data transfer SHALL load a 1024-bit shift register, zero the counter, and enter DRAIN.
REQ-030 In DRAIN, up_ready = 0, m_word_valid = 1, m_word = shift register[31:0], and m_word_last = (counter == 31).
REQ-031 Each m_word transfer SHALL shift the register right by 32 and increment the counter.
REQ-032 The m_word transfer with m_word_last = 1 SHALL return the unpacker to IDLE on the next edge.
REQ-033 m_word and m_word_last SHALL hold stable while m_word_valid = 1 and m_word_ready = 0.
REQ-034 Packer and unpacker SHALL operate independently and concurrently.

Reset
REQ-035 While resetn = 1 at an edge, both halves SHALL go to FILL/IDLE with counters = 0, and the following outputs SHALL be 0: pk_valid, m_word_valid, m_word_last, pk_data, and the shift register.
REQ-036 Immediately after reset, s_word_ready = 1 and up_ready = 1.
REQ-037 Reset mid-operation SHALL discard partial operands and undelivered words, with no spurious valid afterwards.

Structure
REQ-038 A shared package SHALL hold WORD_W = 32, BLOCK_W = 1024, WORDS = 32, CNT_W = 5, and the state encodings.
REQ-039 The unpacker SHALL be the sub-module rsa_word_unpacker; the packer SHALL be inline in rsa_data_bridge.

Verification
REQ-040 Scenario, continuous pack: feed words 0x00000000..0x0000001F back-to-back with pk_ready = 0 -> pk_valid rises the cycle after word 31; pk_data[31:0] = 0, pk_data[1023:992] = 0x1F; s_word_ready = 0 until pk_ready = 1 for one cycle.
REQ-041 Scenario, clear: accept 10 words, then pulse pack_clear with s_word_valid = 1 and s_word = 0xDEAD -> 0xDEAD discarded; the next 32 words form the block, with word 0 at bits [31:0].
REQ-042 Scenario, unpack with backpressure: up_data = {32 words 0xA0+i}, with m_word_ready toggling 1/0 -> m_word sequence 0xA0..0xBF, stable while stalled; m_word_last only on 0xBF; up_ready returns to 1 after it.
REQ-043 Scenario, concurrency: run the pack and unpack streams simultaneously -> both blocks are correct and neither stream stalls the other.
REQ-044 Scenario, reset mid-drain: assert resetn = 1 after 5 of 32 words delivered -> m_word_valid = 0 the next cycle, up_ready = 1, and a fresh block then unpacks from word 0.
REQ-045 Scenario, stress: randomized valid/ready on all four ports over 100 blocks -> no word lost, duplicated, or reordered, checked against a scoreboard.
